// File: rtl/gpio_led_driver_if.sv
// Register-port bundle between the CPU bus/GPIO bridge and gpio_led_driver.
// master: bridge side (drives write strobe, channel index and data).
// slave : driver side (returns registered readback).
interface gpio_led_driver_if;
   logic        wr_i;
   logic [4:0]  addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;

   modport master (
      output wr_i,
      output addr_i,
      output wdata_i,
      input  rdata_o
   );

   modport slave (
      input  wr_i,
      input  addr_i,
      input  wdata_i,
      output rdata_o
   );
endinterface

// File: rtl/gpio_led_driver.sv
// gpio_led_driver: N_LEDS-channel LED/GPIO output driver.
// Each channel is OFF, ON, BLINK (per-channel half-period in prescaler ticks)
// or PWM-dim (shared PWM counter against per-channel duty). Active-low pins
// selected by ACTIVE_LOW_MASK are inverted at the registered output.
// Optional feature macro: LED_DRIVER_TRAP_OVERRIDE_EN adds trap_i, which forces
// every channel to a shared phase toggling on each PWM counter wrap.
module gpio_led_driver #(
   parameter int unsigned              N_LEDS          = 5,
   parameter int unsigned              PWM_BITS        = 8,
   parameter int unsigned              PRESC_DIV       = 125,
   parameter logic [N_LEDS-1:0]        ACTIVE_LOW_MASK = N_LEDS'(5'b01100)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   gpio_led_driver_if.slave    bus,
`ifdef LED_DRIVER_TRAP_OVERRIDE_EN
   input  logic                trap_i,
`endif
   output logic [N_LEDS-1:0]   led_o
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_PWM   = 2'd3
   } mode_t;

   localparam int unsigned        PRESC_W    = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

   // Elaboration-time parameter range checks.
   if (N_LEDS < 1 || N_LEDS > 32) begin : g_bad_n_leds
      $error("gpio_led_driver: N_LEDS must be 1..32");
   end
   if (PWM_BITS < 2 || PWM_BITS > 16) begin : g_bad_pwm_bits
      $error("gpio_led_driver: PWM_BITS must be 2..16");
   end
   if (PRESC_DIV < 1) begin : g_bad_presc
      $error("gpio_led_driver: PRESC_DIV must be >= 1");
   end

   logic [PRESC_W-1:0]  presc_q;
   logic                tick;
   logic [PWM_BITS-1:0] pwm_q;
   logic                pwm_wrap;

   mode_t               mode_q   [N_LEDS];
   logic [PWM_BITS-1:0] duty_q   [N_LEDS];
   logic [7:0]          period_q [N_LEDS];
   logic [7:0]          blink_q  [N_LEDS];
   logic [N_LEDS-1:0]   phase_q;

   logic [N_LEDS-1:0]   wr_hit;
   logic [N_LEDS-1:0]   lit;
   logic [N_LEDS-1:0]   lit_out;
   logic [31:0]         rd_next;

   // Duty bits above PWM_BITS+7 and the mode-field padding are not stored.
   logic unused_wdata;
   assign unused_wdata = ^{bus.wdata_i[7:2], bus.wdata_i[23:8]};

   // Terminal blink count; a half-period of 0 behaves as 1.
   function automatic logic [7:0] blink_last(input logic [7:0] half_period);
      return (half_period == 8'd0) ? 8'd0 : half_period - 8'd1;
   endfunction

   assign tick     = (presc_q == PRESC_LAST);
   assign pwm_wrap = tick && (pwm_q == '1);

   // Prescaler wraps every PRESC_DIV cycles; the shared PWM counter advances per tick.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         presc_q <= '0;
         pwm_q   <= '0;
      end else begin
         presc_q <= tick ? '0 : presc_q + 1'b1;
         if (tick) begin
            pwm_q <= pwm_q + 1'b1;
         end
      end
   end

   // Channel address decode; indices at or above N_LEDS never match.
   always_comb begin
      wr_hit = '0;
      for (int unsigned n = 0; n < N_LEDS; n++) begin
         wr_hit[n] = bus.wr_i && (bus.addr_i == 5'(n));
      end
   end

   // Channel registers and blink state; a write overrides a coincident tick.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned n = 0; n < N_LEDS; n++) begin
            mode_q[n]   <= MODE_OFF;
            duty_q[n]   <= '0;
            period_q[n] <= '0;
            blink_q[n]  <= '0;
         end
         phase_q <= '1;
      end else begin
         for (int unsigned n = 0; n < N_LEDS; n++) begin
            if (wr_hit[n]) begin
               mode_q[n]   <= mode_t'(bus.wdata_i[1:0]);
               duty_q[n]   <= bus.wdata_i[8 +: PWM_BITS];
               period_q[n] <= bus.wdata_i[31:24];
               blink_q[n]  <= '0;
               phase_q[n]  <= 1'b1;
            end else if (mode_q[n] != MODE_BLINK) begin
               blink_q[n] <= '0;
            end else if (tick) begin
               if (blink_q[n] == blink_last(period_q[n])) begin
                  blink_q[n] <= '0;
                  phase_q[n] <= ~phase_q[n];
               end else begin
                  blink_q[n] <= blink_q[n] + 8'd1;
               end
            end
         end
      end
   end

   // Logical (polarity-independent) lit value per channel.
   always_comb begin
      lit = '0;
      for (int unsigned n = 0; n < N_LEDS; n++) begin
         case (mode_q[n])
            MODE_OFF:   lit[n] = 1'b0;
            MODE_ON:    lit[n] = 1'b1;
            MODE_BLINK: lit[n] = phase_q[n];
            MODE_PWM:   lit[n] = (pwm_q < duty_q[n]);
            default:    lit[n] = 1'b0;
         endcase
      end
   end

`ifdef LED_DRIVER_TRAP_OVERRIDE_EN
   logic trap_phase_q;

   // Shared trap phase flips on every PWM counter wrap, whether or not trap_i is set.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         trap_phase_q <= 1'b1;
      end else if (pwm_wrap) begin
         trap_phase_q <= ~trap_phase_q;
      end
   end

   // Trap override replaces every channel's value without touching its registers.
   always_comb begin
      lit_out = trap_i ? {N_LEDS{trap_phase_q}} : lit;
   end
`else
   logic unused_wrap;
   assign unused_wrap = pwm_wrap;

   // Without the trap feature the outputs follow the channel registers only.
   always_comb begin
      lit_out = lit;
   end
`endif

   // Readback word for the addressed channel; out-of-range index reads 0.
   always_comb begin
      rd_next = '0;
      for (int unsigned n = 0; n < N_LEDS; n++) begin
         if (bus.addr_i == 5'(n)) begin
            rd_next[1:0]          = mode_q[n];
            rd_next[8 +: PWM_BITS] = duty_q[n];
            rd_next[31:24]        = period_q[n];
         end
      end
   end

   // Registered pin and readback outputs; pins are polarity-corrected here.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         led_o       <= ACTIVE_LOW_MASK;
         bus.rdata_o <= '0;
      end else begin
         led_o       <= lit_out ^ ACTIVE_LOW_MASK;
         bus.rdata_o <= rd_next;
      end
   end

endmodule

// File: tb/tb_gpio_led_driver.sv
// Testbench for gpio_led_driver (N_LEDS=5, PWM_BITS=4, PRESC_DIV=4, mask 5'b01100).
// Stimulus pushes the expected led_o/rdata_o for every clock edge into a queue;
// a separate monitor pops and compares after each edge. The reference model
// derives blink/PWM/trap state in closed form from the edge count since reset.
module tb_gpio_led_driver;

   localparam int unsigned N     = 5;
   localparam int unsigned PB    = 4;
   localparam int unsigned P     = 4;
   localparam int unsigned PMOD  = 16;
   localparam logic [N-1:0] MASK = 5'b01100;

   typedef struct {
      int unsigned idx;
      logic [N-1:0] led;
      logic [31:0]  rd;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         trap;
   logic [N-1:0] led;

   gpio_led_driver_if bus ();

   gpio_led_driver #(
      .N_LEDS(N),
      .PWM_BITS(PB),
      .PRESC_DIV(P),
      .ACTIVE_LOW_MASK(MASK)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus(bus),
`ifdef LED_DRIVER_TRAP_OVERRIDE_EN
      .trap_i(trap),
`endif
      .led_o(led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t        exp_q[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned step_no = 0;

   // Reference model: channel state before the current non-reset edge.
   int unsigned ecount = 0;
   int unsigned m_mode [N];
   int unsigned m_duty [N];
   int unsigned m_per  [N];
   int unsigned m_wt   [N];

   function automatic logic model_lit(int unsigned n, int unsigned j, logic tr);
      int unsigned hp;
      int unsigned k;
      if (tr) return ((j / (P * PMOD)) % 2) == 0;
      case (m_mode[n])
         0: return 1'b0;
         1: return 1'b1;
         2: begin
            hp = (m_per[n] == 0) ? 1 : m_per[n];
            k  = j / P - (m_wt[n] + 1) / P;
            return ((k / hp) % 2) == 0;
         end
         default: return ((j / P) % PMOD) < m_duty[n];
      endcase
   endfunction

   function automatic logic [31:0] model_rb(int unsigned a);
      logic [31:0] r;
      r = '0;
      if (a < N) begin
         r[1:0]   = 2'(m_mode[a]);
         r[11:8]  = 4'(m_duty[a]);
         r[31:24] = 8'(m_per[a]);
      end
      return r;
   endfunction

   // One clock edge: drive inputs, queue the expectation, advance the model.
   task automatic step(input logic r, input logic wr, input logic [4:0] a,
                       input logic [31:0] d, input logic tr);
      exp_t e;
      rst         = r;
      trap        = tr;
      bus.wr_i    = wr;
      bus.addr_i  = a;
      bus.wdata_i = d;
      e.idx = step_no;
      if (r) begin
         e.led = MASK;
         e.rd  = '0;
      end else begin
         for (int unsigned n = 0; n < N; n++) e.led[n] = model_lit(n, ecount, tr) ^ MASK[n];
         e.rd = model_rb(a);
      end
      exp_q.push_back(e);
      if (r) begin
         ecount = 0;
         for (int unsigned n = 0; n < N; n++) begin
            m_mode[n] = 0; m_duty[n] = 0; m_per[n] = 0; m_wt[n] = 0;
         end
      end else begin
         if (wr && a < N) begin
            m_mode[a] = d[1:0];
            m_duty[a] = d[11:8];
            m_per[a]  = d[31:24];
            m_wt[a]   = ecount;
         end
         ecount++;
      end
      step_no++;
      @(negedge clk);
   endtask

   task automatic idle(input int unsigned cycles, input logic tr);
      for (int unsigned i = 0; i < cycles; i++) step(1'b0, 1'b0, 5'(i % 8), $urandom, tr);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, a, d, 1'b0);
   endtask

   // Monitor: compare DUT outputs after every edge against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (led !== e.led) begin
               errors++;
               $display("FAIL led_o step %0d: got %b expected %b", e.idx, led, e.led);
            end
            checks++;
            if (bus.rdata_o !== e.rd) begin
               errors++;
               $display("FAIL rdata_o step %0d: got %h expected %h", e.idx, bus.rdata_o, e.rd);
            end
         end
      end
   end

   // Watchdog bounding the whole run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   // Stimulus.
   initial begin
      logic [31:0] d;
      // Reset held 3 cycles; the last one also carries a write to ch3 that must be lost.
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      step(1'b1, 1'b1, 5'd3, 32'h0000_0001, 1'b0);
      idle(8, 1'b0);

      // ch0 ON, then ch2 ON (ch2 is active-low).
      wr(5'd0, 32'h0000_0001);
      idle(3, 1'b0);
      wr(5'd2, 32'h0000_0001);
      idle(3, 1'b0);

      // ch1 BLINK with half-period 3, rewritten part way through, then half-period 0.
      wr(5'd1, 32'h0300_0002);
      idle(17, 1'b0);
      wr(5'd1, 32'h0300_0002);
      idle(40, 1'b0);
      wr(5'd1, 32'h0000_0002);
      idle(12, 1'b0);

      // ch4 PWM at duty 4, 0, 15 (full PWM period is 64 cycles).
      wr(5'd4, 32'h0000_0403);
      idle(70, 1'b0);
      wr(5'd4, 32'h0000_0003);
      idle(70, 1'b0);
      wr(5'd4, 32'hFFFF_FF03);
      idle(70, 1'b0);

      // Out-of-range writes have no effect; readback sweeps all indices.
      wr(5'd7, 32'hFFFF_FFFF);
      wr(5'd31, 32'h0300_0002);
      idle(16, 1'b0);

      // Write and read of the same channel in one cycle returns the old value.
      wr(5'd3, 32'h0200_0502);
      wr(5'd3, 32'h0000_0001);
      idle(4, 1'b0);

`ifdef LED_DRIVER_TRAP_OVERRIDE_EN
      // Trap override with mixed channel modes, then release.
      wr(5'd0, 32'h0000_0000);
      wr(5'd1, 32'h0100_0002);
      wr(5'd2, 32'h0000_0001);
      wr(5'd4, 32'h0000_0803);
      idle(140, 1'b1);
      idle(20, 1'b0);
`endif

      // Randomised traffic.
      for (int unsigned i = 0; i < 900; i++) begin
         d = $urandom;
         d[31:24] = 8'($urandom_range(0, 4));
         if ($urandom_range(0, 7) == 0)
            step(1'b0, 1'b1, 5'($urandom_range(0, 7)), d, 1'b0);
         else
            step(1'b0, 1'b0, 5'($urandom_range(0, 7)), d, 1'b0);
      end

      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
